// File: rtl/pipe_pkg.sv
// Shared EX/MEM pipeline types: control record, write-back source codes,
// load/store size codes and the branch-taken helper.
package pipe_pkg;

  // Write-back source select carried on mem_to_reg
  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC4 = 2'd2;

  // Memory access size (funct3 of loads/stores)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Control half of the EX/MEM register; zeroed for bubbles and wrong-path slots
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic       jalr;
    logic       taken;
  } ex_mem_ctrl_t;

  // Full EX/MEM record at the default 32-bit / 5-bit widths
  typedef struct packed {
    ex_mem_ctrl_t ctrl;
    logic [2:0]   funct3;
    logic [4:0]   rd;
    logic [31:0]  alu_result;
    logic [31:0]  store_data;
    logic [31:0]  pc_four;
    logic [31:0]  pc_imm;
  } ex_mem_t;

  // A live instruction leaves the fall-through path on a true branch or any jump
  function automatic logic is_taken(input logic valid, input logic branch,
                                    input logic zero, input logic jump);
    return valid & ((branch & zero) | jump);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: stops at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc unless already pinned at the maximum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch/jump redirect generation and
// taken/retire performance counters.
module ex_mem_stage
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  zero_i,
  input  logic                  branch_i,
  input  logic                  jump_i,
  input  logic                  jalr_i,
  input  logic [DATA_WIDTH-1:0] pc_imm_i,
  input  logic [DATA_WIDTH-1:0] pc_four_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic [2:0]            funct3_i,
  input  logic                  reg_write_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [1:0]            mem_to_reg_i,
  input  logic                  stall_i,
  output logic                  ex_ready_o,
  output logic                  mem_valid_o,
  output logic [DATA_WIDTH-1:0] alu_result_o,
  output logic [DATA_WIDTH-1:0] store_data_o,
  output logic [DATA_WIDTH-1:0] pc_four_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [2:0]            funct3_o,
  output logic                  reg_write_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [1:0]            mem_to_reg_o,
  output logic                  redirect_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o,
  output logic                  flush_o,
  output logic [CNT_W-1:0]      taken_cnt_o,
  output logic [CNT_W-1:0]      retire_cnt_o
);

  // Datapath half of the register, sized by the module parameters
  typedef struct packed {
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] store_data;
    logic [DATA_WIDTH-1:0] pc_four;
    logic [DATA_WIDTH-1:0] pc_imm;
    logic [REG_ADDR_W-1:0] rd;
    logic [2:0]            funct3;
  } payload_t;

  payload_t     pl_q, pl_d;
  ex_mem_ctrl_t ctrl_q, ctrl_d;
  logic         vld_q, vld_d;
  logic         redir_done_q;
  logic         capture;
  logic         redirect;

  assign capture    = !stall_i;
  assign ex_ready_o = capture;

  // A resident taken instruction redirects only in its first cycle in MEM
  assign redirect = vld_q & ctrl_q.taken & !redir_done_q;

  // Next register contents; the slot behind a redirect is wrong-path and dies
  always_comb begin
    vld_d     = ex_valid_i & !redirect;
    pl_d      = '{alu_result: alu_result_i, store_data: store_data_i,
                  pc_four: pc_four_i, pc_imm: pc_imm_i,
                  rd: rd_i, funct3: funct3_i};
    ctrl_d    = '0;
    if (vld_d) begin
      ctrl_d.reg_write  = reg_write_i;
      ctrl_d.mem_read   = mem_read_i;
      ctrl_d.mem_write  = mem_write_i;
      ctrl_d.mem_to_reg = mem_to_reg_i;
      ctrl_d.jalr       = jalr_i;
      ctrl_d.taken      = is_taken(ex_valid_i, branch_i, zero_i, jump_i);
    end
  end

  // EX/MEM register: loads on every unstalled edge, holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      pl_q   <= '0;
      ctrl_q <= '0;
    end else if (capture) begin
      vld_q  <= vld_d;
      pl_q   <= pl_d;
      ctrl_q <= ctrl_d;
    end
  end

  // Remember that the resident instruction has already redirected so a
  // stall cannot stretch the pulse; a fresh capture re-arms it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        redir_done_q <= 1'b0;
    else if (capture)  redir_done_q <= 1'b0;
    else if (redirect) redir_done_q <= 1'b1;
  end

  // Redirect target: JALR clears bit 0 of the ALU sum, others use PC+imm
  always_comb begin
    redirect_pc_o = '0;
    if (redirect) begin
      if (ctrl_q.jalr) redirect_pc_o = {pl_q.alu_result[DATA_WIDTH-1:1], 1'b0};
      else             redirect_pc_o = pl_q.pc_imm;
    end
  end

  assign redirect_o   = redirect;
  assign flush_o      = redirect;
  assign mem_valid_o  = vld_q;
  assign alu_result_o = pl_q.alu_result;
  assign store_data_o = pl_q.store_data;
  assign pc_four_o    = pl_q.pc_four;
  assign rd_o         = pl_q.rd;
  assign funct3_o     = pl_q.funct3;
  assign reg_write_o  = ctrl_q.reg_write;
  assign mem_read_o   = ctrl_q.mem_read;
  assign mem_write_o  = ctrl_q.mem_write;
  assign mem_to_reg_o = ctrl_q.mem_to_reg;

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect),
    .cnt   (taken_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (vld_q & !stall_i),
    .cnt   (retire_cnt_o)
  );

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed cases then random traffic with
// occasional resets, checked against an instruction-level reference model.
module tb_ex_mem_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_valid_i, zero_i, branch_i, jump_i, jalr_i;
  logic [DW-1:0] alu_result_i, pc_imm_i, pc_four_i, store_data_i;
  logic [RW-1:0] rd_i;
  logic [2:0]    funct3_i;
  logic          reg_write_i, mem_read_i, mem_write_i, stall_i;
  logic [1:0]    mem_to_reg_i;
  logic          ex_ready_o, mem_valid_o, reg_write_o, mem_read_o, mem_write_o;
  logic [DW-1:0] alu_result_o, store_data_o, pc_four_o, redirect_pc_o;
  logic [RW-1:0] rd_o;
  logic [2:0]    funct3_o;
  logic [1:0]    mem_to_reg_o;
  logic          redirect_o, flush_o;
  logic [CW-1:0] taken_cnt_o, retire_cnt_o;

  ex_mem_stage #(.DATA_WIDTH(DW), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid_i), .alu_result_i(alu_result_i),
    .zero_i(zero_i), .branch_i(branch_i), .jump_i(jump_i), .jalr_i(jalr_i),
    .pc_imm_i(pc_imm_i), .pc_four_i(pc_four_i), .store_data_i(store_data_i),
    .rd_i(rd_i), .funct3_i(funct3_i), .reg_write_i(reg_write_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i),
    .stall_i(stall_i), .ex_ready_o(ex_ready_o), .mem_valid_o(mem_valid_o),
    .alu_result_o(alu_result_o), .store_data_o(store_data_o), .pc_four_o(pc_four_o),
    .rd_o(rd_o), .funct3_o(funct3_o), .reg_write_o(reg_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .flush_o(flush_o),
    .taken_cnt_o(taken_cnt_o), .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        ev, z, br, j, jr, rw, mr, mw, stall;
    bit [31:0] alu, pcimm, pc4, sd;
    bit [4:0]  rd;
    bit [2:0]  f3;
    bit [1:0]  m2r;
  } stim_t;

  typedef struct {
    bit        rdy, vld, redir, rw, mr, mw;
    bit [31:0] rpc, alu, sd, pc4;
    bit [4:0]  rd;
    bit [2:0]  f3;
    bit [1:0]  m2r;
    int        tcnt, rcnt;
  } exp_t;

  // Reference model: which instruction sits in MEM, whether it is a taken
  // control transfer, and how many cycles it has been resident
  bit    m_v, m_taken;
  int    m_age;
  stim_t m_i;
  int    c_t, c_r;

  exp_t  sbq[$];
  stim_t cur;
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string nm, input longint a, input longint e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.ev    = ($urandom_range(0, 9) < 8);
    s.br    = ($urandom_range(0, 3) == 0);
    s.z     = $urandom_range(0, 1);
    s.j     = ($urandom_range(0, 9) == 0);
    s.jr    = s.j && $urandom_range(0, 1);
    s.rw    = $urandom_range(0, 1);
    s.mr    = $urandom_range(0, 1);
    s.mw    = $urandom_range(0, 1);
    s.m2r   = 2'($urandom_range(0, 2));
    s.stall = ($urandom_range(0, 3) == 0);
    s.alu   = $urandom;
    s.pcimm = $urandom;
    s.pc4   = $urandom;
    s.sd    = $urandom;
    s.rd    = 5'($urandom);
    s.f3    = 3'($urandom);
    return s;
  endfunction

  function automatic bit model_redirect();
    return m_v && m_taken && (m_age == 0);
  endfunction

  function automatic void model_clear();
    m_v = 0; m_taken = 0; m_age = 0; m_i = nop(); c_t = 0; c_r = 0;
  endfunction

  // Advance the model across one rising edge with the inputs that were held
  function automatic void model_edge(input stim_t s, input bit rstn);
    bit redir;
    if (!rstn) begin
      model_clear();
      return;
    end
    redir = model_redirect();
    if (redir) c_t = (c_t + 1 > CMAX) ? CMAX : c_t + 1;
    if (m_v && !s.stall) c_r = (c_r + 1 > CMAX) ? CMAX : c_r + 1;
    if (!s.stall) begin
      m_v     = s.ev && !redir;
      m_i     = s;
      m_taken = m_v && ((s.br && s.z) || s.j);
      m_age   = 0;
    end else begin
      m_age++;
    end
  endfunction

  function automatic exp_t model_out(input bit stall);
    exp_t e;
    e       = '{default: 0};
    e.rdy   = !stall;
    e.vld   = m_v;
    e.redir = model_redirect();
    e.rpc   = !e.redir ? 32'd0 : (m_i.jr ? (m_i.alu & 32'hFFFF_FFFE) : m_i.pcimm);
    if (m_v) begin
      e.rw = m_i.rw; e.mr = m_i.mr; e.mw = m_i.mw; e.m2r = m_i.m2r;
    end
    e.alu = m_i.alu; e.sd = m_i.sd; e.pc4 = m_i.pc4; e.rd = m_i.rd; e.f3 = m_i.f3;
    e.tcnt = c_t;
    e.rcnt = c_r;
    return e;
  endfunction

  task automatic apply(input stim_t s);
    ex_valid_i = s.ev; zero_i = s.z; branch_i = s.br; jump_i = s.j; jalr_i = s.jr;
    alu_result_i = s.alu; pc_imm_i = s.pcimm; pc_four_i = s.pc4; store_data_i = s.sd;
    rd_i = s.rd; funct3_i = s.f3; reg_write_i = s.rw; mem_read_i = s.mr;
    mem_write_i = s.mw; mem_to_reg_i = s.m2r; stall_i = s.stall;
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid", mem_valid_o, 0);
    chk("rst_redirect", redirect_o, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_rpc", redirect_pc_o, 0);
    chk("rst_ctrl", {reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o}, 0);
    chk("rst_payload", {alu_result_o, rd_o, pc_four_o}, 0);
    chk("rst_cnts", {taken_cnt_o, retire_cnt_o}, 0);
  endtask

  // One clock: retire the edge in the model, drive the next inputs, optionally
  // pulse reset mid-cycle, then post this cycle's expectation
  task automatic cycle(input stim_t nxt, input bit do_rst, input bit release_rst);
    @(posedge clk);
    #1;
    model_edge(cur, rst_n);
    if (release_rst) rst_n = 1'b1;
    cur = nxt;
    apply(cur);
    if (do_rst) begin
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      model_clear();
    end
    sbq.push_back(model_out(cur.stall));
  endtask

  // Monitor: compare the DUT against the oldest posted expectation
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("ex_ready", ex_ready_o, e.rdy);
      chk("mem_valid", mem_valid_o, e.vld);
      chk("redirect", redirect_o, e.redir);
      chk("flush", flush_o, e.redir);
      chk("redirect_pc", redirect_pc_o, e.rpc);
      chk("ctrl", {reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o},
          {e.rw, e.mr, e.mw, e.m2r});
      if (e.vld) begin
        chk("alu_result", alu_result_o, e.alu);
        chk("store_data", store_data_o, e.sd);
        chk("pc_four", pc_four_o, e.pc4);
        chk("rd_f3", {rd_o, funct3_o}, {e.rd, e.f3});
      end
      chk("taken_cnt", taken_cnt_o, e.tcnt);
      chk("retire_cnt", retire_cnt_o, e.rcnt);
    end
  end

  initial begin
    stim_t s;
    cur = nop();
    apply(cur);
    model_clear();
    #3;
    check_reset_outputs();
    @(posedge clk);

    // ADD capture, released from reset on the same cycle
    s = nop(); s.ev = 1; s.alu = 32'h10; s.rd = 5; s.rw = 1;
    cycle(s, 0, 1);
    cycle(nop(), 0, 0);
    // Taken BEQ followed by a wrong-path instruction
    s = nop(); s.ev = 1; s.br = 1; s.z = 1; s.pcimm = 32'h100;
    cycle(s, 0, 0);
    s = nop(); s.ev = 1; s.rw = 1; s.rd = 7;
    cycle(s, 0, 0);
    cycle(nop(), 0, 0);
    // JALR with odd ALU sum
    s = nop(); s.ev = 1; s.j = 1; s.jr = 1; s.alu = 32'h203; s.pc4 = 32'h44; s.rw = 1;
    s.m2r = 2'd2;
    cycle(s, 0, 0);
    cycle(nop(), 0, 0);
    // Taken branch then a 3-cycle stall
    s = nop(); s.ev = 1; s.br = 1; s.z = 1; s.pcimm = 32'h300;
    cycle(s, 0, 0);
    s = nop(); s.ev = 1; s.stall = 1;
    for (int k = 0; k < 3; k++) cycle(s, 0, 0);
    cycle(nop(), 0, 0);
    // Reset while stalled on a taken branch, then resume
    s = nop(); s.ev = 1; s.j = 1; s.pcimm = 32'h500;
    cycle(s, 0, 0);
    s = nop(); s.stall = 1;
    cycle(s, 0, 0);
    cycle(s, 1, 0);
    s = nop(); s.ev = 1; s.rw = 1; s.alu = 32'h77;
    cycle(s, 0, 1);
    cycle(nop(), 0, 0);
    // Long retire burst to push counters into saturation
    for (int k = 0; k < 20; k++) begin
      s = nop(); s.ev = 1; s.rw = 1; s.alu = k;
      cycle(s, 0, 0);
    end

    // Random traffic with occasional mid-stall resets
    for (int i = 0; i < 800; i++) begin
      s = rnd();
      if (i % 150 == 75) begin
        s.stall = 1;
        cycle(s, 1, 0);
        cycle(rnd(), 0, 1);
      end else begin
        cycle(s, 0, 0);
      end
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the width of the datapath and PC.
REQ-002 Parameter REG_ADDR_W, default 5, sets the width of the register index.
REQ-003 Parameter CNT_W, default 16, sets the width of the performance counters.
REQ-004 One clock, clk; reset rst_n is asynchronous and active-low; clk and rst_n are the first ports.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 ex_valid_i  in  1  EX holds a live instruction.
REQ-008 alu_result_i  in  DATA_WIDTH  ALUResult from the ALU.
REQ-009 zero_i  in  1  ALU Zero, meaning the branch condition is true.
REQ-010 branch_i, jump_i, jalr_i  in  1 each  control class of the EX instruction.
REQ-011 pc_imm_i, pc_four_i  in  DATA_WIDTH  branch target (PC+imm) and PC+4.
REQ-012 store_data_i  in  DATA_WIDTH  forwarded rs2 value.
REQ-013 rd_i  in  REG_ADDR_W  destination register index.
REQ-014 funct3_i  in  3  memory access size.
REQ-015 reg_write_i, mem_read_i, mem_write_i  in  1 each  write-back and memory controls.
REQ-016 mem_to_reg_i  in  2  write-back source select.
REQ-017 stall_i  in  1  MEM cannot accept an instruction.
REQ-018 ex_ready_o  out  1  this stage accepts the EX instruction; equals !stall_i.
REQ-019 mem_valid_o plus registered copies (alu_result_o, store_data_o, pc_four_o, rd_o, funct3_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o)  out  matching widths  MEM-stage payload.
REQ-020 redirect_o  out  1  single-cycle pulse requesting a PC redirect.
REQ-021 redirect_pc_o  out  DATA_WIDTH  PC redirect target.
REQ-022 flush_o  out  1  clear IF/ID and ID/EX; equals redirect_o.
REQ-023 taken_cnt_o, retire_cnt_o  out  CNT_W each  performance counters.

Function
REQ-024 taken = ex_valid_i & ((branch_i & zero_i) | jump_i); taken is evaluated at capture time and registered as taken_q.
REQ-025 Capture occurs when ex_ready_o=1; the register loads the payload and sets mem_valid_o=ex_valid_i & !redirect_o.
REQ-026 While redirect_o=1 the incoming instruction is wrong-path; mem_valid_o is loaded with 0, all control bits are zeroed, and the payload is don't-care.
REQ-027 While stall_i=1 every registered output holds its value; ex_ready_o=0.
REQ-028 redirect_o = mem_valid_o & taken_q & !redir_done.
REQ-029 redir_done is set when redirect_o=1, and is cleared on any new capture.
REQ-030 redirect_o is a single-cycle pulse even when stall_i holds the instruction for multiple cycles.
REQ-031 redirect_pc_o = (alu_result_q & ~1) when jalr_q=1; otherwise redirect_pc_o = pc_imm_q.
REQ-032 redirect_pc_o is 0 when redirect_o=0.
REQ-033 Latency: EX to MEM visibility is 1 cycle; a redirect appears in the cycle after the branch is captured.
REQ-034 A captured bubble (ex_valid_i=0) forces all control outputs to 0.
REQ-035 taken_cnt_o increments on each redirect_o pulse.
REQ-036 retire_cnt_o increments each cycle with mem_valid_o & !stall_i.
REQ-037 taken_cnt_o and retire_cnt_o saturate at all-ones and do not wrap.
REQ-038 When stall_i and a taken branch coincide, stall takes precedence for capture; the redirect still pulses once.

Reset
REQ-039 rst_n low asynchronously clears mem_valid_o, all control outputs, the payload, taken_q, redir_done, and both counters to 0.
REQ-040 While rst_n is low, redirect_o=0, flush_o=0 and redirect_pc_o=0.
REQ-041 Reset asserted mid-stall or mid-redirect discards the held instruction and leaves no pending pulse.
REQ-042 After rst_n is released, the first capture occurs on the first rising edge with stall_i=0.

Structure
REQ-043 Package pipe_pkg holds the ex_mem_t struct (payload and control fields), the mem_to_reg encodings, and the funct3 size constants.
REQ-044 Sub-module sat_counter (parameter W; inputs clk, rst_n, inc; output cnt) is instantiated twice, once per performance counter.

Verification
REQ-045 ADD capture: alu_result_i=0x0000_0010, rd_i=5, reg_write_i=1 -> next cycle mem_valid_o=1, alu_result_o=0x10, rd_o=5, redirect_o=0.
REQ-046 Taken BEQ: branch_i=1, zero_i=1, pc_imm_i=0x100 -> next cycle redirect_o=1, flush_o=1, redirect_pc_o=0x100; the following capture has mem_valid_o=0; taken_cnt_o=1.
REQ-047 JALR: jalr_i=1, jump_i=1, alu_result_i=0x0000_0203 -> redirect_pc_o=0x202, pc_four_o carried unchanged.
REQ-048 Stall: taken branch captured, then stall_i=1 for 3 cycles -> redirect_o high exactly 1 cycle, all outputs stable, retire_cnt_o unchanged until stall_i=0.
REQ-049 Saturation: CNT_W=4, 20 retiring instructions -> retire_cnt_o=0xF.
REQ-050 Reset mid-stall: rst_n low while stall_i=1 -> all outputs 0 immediately; after release, the next capture proceeds normally.
